ddram_bridge: RTL and testbench

DDRAM_BRIDGE -- requirements
Module: ddram_bridge

---
 rtl/ddram_bridge_if.sv | 23 ++
 rtl/ddram_bridge.sv | 186 ++++++++++++++++++
 tb/tb_ddram_bridge.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ddram_bridge_if.sv
// Avalon-MM port between the byte bridge and the DDR3 controller.
// The bridge drives the command side through modport master; the memory model uses modport slave.
interface ddram_bridge_if;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;

    modport master (
        input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );

    modport slave (
        output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );
endinterface

// File: rtl/ddram_bridge.sv
// Edge-triggered byte-wide access to a 2 MB window of 64-bit DDR3 words.
// Defining DDRAM_BRIDGE_CACHE_EN adds a single-line read cache.
module ddram_bridge #(
    parameter logic [28:0] BASE_ADDR = 29'h0600000
) (
    input  logic           DDRAM_CLK,
    input  logic           reset_n,
    input  logic [20:0]    addr,
    input  logic [7:0]     din,
    output logic [7:0]     dout,
    input  logic           rd,
    input  logic           we,
    output logic           ready,
    ddram_bridge_if.master ddr
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT
    } state_t;

    state_t      state, state_n;
    logic        rd_q, we_q;
    logic [20:0] addr_q, addr_n;
    logic [7:0]  din_q, din_n;
    logic        ready_q, ready_n;
    logic        ddr_rd_q, ddr_rd_n;
    logic        ddr_we_q, ddr_we_n;
    logic [7:0]  be_q, be_n;
    logic [7:0]  dout_q, dout_n;
    logic        rd_rise, we_rise;
    logic [5:0]  lane;

`ifdef DDRAM_BRIDGE_CACHE_EN
    logic [63:0] line_q, line_n;
    logic [17:0] tag_q, tag_n;
    logic        valid_q, valid_n;
    logic        hit_q, hit_n;
`endif

    assign rd_rise = rd & ~rd_q;
    assign we_rise = we & ~we_q;
    assign lane    = {addr_q[2:0], 3'b000};

    assign ready              = ready_q;
    assign dout               = dout_q;
    assign ddr.DDRAM_BURSTCNT = 8'd1;
    assign ddr.DDRAM_ADDR     = BASE_ADDR + {11'b0, addr_q[20:3]};
    assign ddr.DDRAM_DIN      = {8{din_q}};
    assign ddr.DDRAM_BE       = be_q;
    assign ddr.DDRAM_RD       = ddr_rd_q;
    assign ddr.DDRAM_WE       = ddr_we_q;

    always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rd_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            ready_q  <= 1'b1;
            ddr_rd_q <= 1'b0;
            ddr_we_q <= 1'b0;
            be_q     <= '0;
            dout_q   <= '0;
`ifdef DDRAM_BRIDGE_CACHE_EN
            line_q   <= '0;
            tag_q    <= '0;
            valid_q  <= 1'b0;
            hit_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            rd_q     <= rd;
            we_q     <= we;
            addr_q   <= addr_n;
            din_q    <= din_n;
            ready_q  <= ready_n;
            ddr_rd_q <= ddr_rd_n;
            ddr_we_q <= ddr_we_n;
            be_q     <= be_n;
            dout_q   <= dout_n;
`ifdef DDRAM_BRIDGE_CACHE_EN
            line_q   <= line_n;
            tag_q    <= tag_n;
            valid_q  <= valid_n;
            hit_q    <= hit_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        addr_n   = addr_q;
        din_n    = din_q;
        ready_n  = ready_q;
        ddr_rd_n = ddr_rd_q;
        ddr_we_n = ddr_we_q;
        be_n     = be_q;
        dout_n   = dout_q;
`ifdef DDRAM_BRIDGE_CACHE_EN
        line_n   = line_q;
        tag_n    = tag_q;
        valid_n  = valid_q;
        hit_n    = hit_q;
`endif

        case (state)
            IDLE: begin
                // A write wins over a read that rises in the same cycle; the read is lost.
                if (we_rise) begin
                    addr_n   = addr;
                    din_n    = din;
                    be_n     = 8'd1 << addr[2:0];
                    ddr_we_n = 1'b1;
                    ready_n  = 1'b0;
                    state_n  = WR;
`ifdef DDRAM_BRIDGE_CACHE_EN
                    if (valid_q && (tag_q == addr[20:3])) begin
                        line_n[{addr[2:0], 3'b000} +: 8] = din;
                    end
`endif
                end else if (rd_rise) begin
                    addr_n  = addr;
                    ready_n = 1'b0;
`ifdef DDRAM_BRIDGE_CACHE_EN
                    if (valid_q && (tag_q == addr[20:3])) begin
                        hit_n   = 1'b1;
                        state_n = RD_WAIT;
                    end else begin
                        ddr_rd_n = 1'b1;
                        state_n  = RD_REQ;
                    end
`else
                    ddr_rd_n = 1'b1;
                    state_n  = RD_REQ;
`endif
                end
            end

            WR: begin
                if (!ddr.DDRAM_BUSY) begin
                    ddr_we_n = 1'b0;
                    ready_n  = 1'b1;
                    state_n  = IDLE;
                end
            end

            RD_REQ: begin
                if (!ddr.DDRAM_BUSY) begin
                    ddr_rd_n = 1'b0;
                    state_n  = RD_WAIT;
                end
            end

            RD_WAIT: begin
`ifdef DDRAM_BRIDGE_CACHE_EN
                // A cache hit parks here for one cycle so dout and ready move together.
                if (hit_q) begin
                    dout_n  = line_q[lane +: 8];
                    ready_n = 1'b1;
                    hit_n   = 1'b0;
                    state_n = IDLE;
                end else
`endif
                if (ddr.DDRAM_DOUT_READY) begin
                    dout_n  = ddr.DDRAM_DOUT[lane +: 8];
                    ready_n = 1'b1;
                    state_n = IDLE;
`ifdef DDRAM_BRIDGE_CACHE_EN
                    line_n  = ddr.DDRAM_DOUT;
                    tag_n   = addr_q[20:3];
                    valid_n = 1'b1;
`endif
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ddram_bridge.sv
// Directed bench for ddram_bridge with a behavioural Avalon responder and a dout scoreboard.
// Build with DDRAM_BRIDGE_CACHE_EN defined to exercise the read cache expectations.
module tb_ddram_bridge;

    localparam logic [28:0] BASE = 29'h0600000;
`ifdef DDRAM_BRIDGE_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        DDRAM_CLK;
    logic        reset_n;
    logic [20:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        rd;
    logic        we;
    logic        ready;

    ddram_bridge_if bus ();

    ddram_bridge #(.BASE_ADDR(BASE)) dut (
        .DDRAM_CLK (DDRAM_CLK),
        .reset_n   (reset_n),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .rd        (rd),
        .we        (we),
        .ready     (ready),
        .ddr       (bus.master)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    initial DDRAM_CLK = 1'b0;
    always #5 DDRAM_CLK = ~DDRAM_CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [20:0] a, input logic [7:0] d, input int busy_n);
        int  we_cyc = 0;
        int  rlow   = 0;
        bit  done   = 1'b0;
        logic [7:0] exp_be;
        exp_be = 8'd1 << a[2:0];
        rd = 1'b0;
        we = 1'b0;
        @(negedge DDRAM_CLK);
        addr = a;
        din  = d;
        we   = 1'b1;
        bus.DDRAM_BUSY = (busy_n > 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge DDRAM_CLK);
            if (ready === 1'b0) rlow++;
            else if (rlow > 0) begin
                done = 1'b1;
                break;
            end
            if (bus.DDRAM_WE === 1'b1) begin
                we_cyc++;
                if (we_cyc == 1) begin
                    chk("wr_addr", 64'(bus.DDRAM_ADDR), 64'(BASE + {11'b0, a[20:3]}));
                    chk("wr_be",   64'(bus.DDRAM_BE), 64'(exp_be));
                    chk("wr_din",  bus.DDRAM_DIN, {8{d}});
                end
                bus.DDRAM_BUSY = (we_cyc <= busy_n);
            end
        end
        we = 1'b0;
        bus.DDRAM_BUSY = 1'b0;
        chk("wr_done", 64'(done), 64'(1));
        chk("wr_we_cycles", 64'(we_cyc), 64'(busy_n + 1));
        chk("wr_ready_low", 64'(rlow), 64'(busy_n + 1));
    endtask

    task automatic do_read(input logic [20:0] a, input int busy_n, input int lat,
                           input logic [63:0] word, input int exp_rd, input int exp_low);
        int  rd_cyc   = 0;
        int  wait_cnt = 0;
        int  rlow     = 0;
        bit  acc      = 1'b0;
        bit  done     = 1'b0;
        logic [63:0] w;
        logic [7:0]  exp_dout;
        w  = word;
        rd = 1'b0;
        we = 1'b0;
        @(negedge DDRAM_CLK);
        sb.push_back(w[{a[2:0], 3'b000} +: 8]);
        addr = a;
        rd   = 1'b1;
        bus.DDRAM_BUSY = (busy_n > 0);
        for (int i = 0; i < 60; i++) begin
            @(negedge DDRAM_CLK);
            bus.DDRAM_DOUT_READY = 1'b0;
            if (ready === 1'b0) rlow++;
            else if (rlow > 0) begin
                done = 1'b1;
                break;
            end
            if (bus.DDRAM_RD === 1'b1) rd_cyc++;
            if (acc) begin
                wait_cnt++;
                if (wait_cnt == lat) begin
                    bus.DDRAM_DOUT_READY = 1'b1;
                    bus.DDRAM_DOUT       = w;
                end
            end else if (bus.DDRAM_RD === 1'b1) begin
                if (rd_cyc == 1) chk("rd_addr", 64'(bus.DDRAM_ADDR), 64'(BASE + {11'b0, a[20:3]}));
                bus.DDRAM_BUSY = (rd_cyc <= busy_n);
                acc = !bus.DDRAM_BUSY;
                // Stray valid while the command is still pending must not complete the read.
                bus.DDRAM_DOUT_READY = 1'b1;
                bus.DDRAM_DOUT       = 64'hDEADBEEFCAFEF00D;
            end
        end
        bus.DDRAM_DOUT_READY = 1'b0;
        bus.DDRAM_BUSY       = 1'b0;
        rd = 1'b0;
        exp_dout = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        chk("rd_done", 64'(done), 64'(1));
        chk("rd_dout", 64'(dout), 64'(exp_dout));
        chk("rd_cmd_cycles", 64'(rd_cyc), 64'(exp_rd));
        chk("rd_ready_low", 64'(rlow), 64'(exp_low));
    endtask

    initial begin
        int we_cyc;
        int rd_cyc;

        reset_n = 1'b0;
        addr    = '0;
        din     = '0;
        rd      = 1'b0;
        we      = 1'b0;
        bus.DDRAM_BUSY       = 1'b0;
        bus.DDRAM_DOUT       = '0;
        bus.DDRAM_DOUT_READY = 1'b0;

        repeat (3) @(negedge DDRAM_CLK);
        chk("rst_ready",    64'(ready), 64'(1));
        chk("rst_rd",       64'(bus.DDRAM_RD), 64'(0));
        chk("rst_we",       64'(bus.DDRAM_WE), 64'(0));
        chk("rst_dout",     64'(dout), 64'(0));
        chk("rst_be",       64'(bus.DDRAM_BE), 64'(0));
        chk("rst_din",      bus.DDRAM_DIN, 64'(0));
        chk("rst_addr",     64'(bus.DDRAM_ADDR), 64'(BASE));
        chk("rst_burstcnt", 64'(bus.DDRAM_BURSTCNT), 64'(1));
        reset_n = 1'b1;

        // Valid outside a read is ignored.
        @(negedge DDRAM_CLK);
        bus.DDRAM_DOUT_READY = 1'b1;
        bus.DDRAM_DOUT       = 64'hFFFFFFFFFFFFFFFF;
        @(negedge DDRAM_CLK);
        bus.DDRAM_DOUT_READY = 1'b0;
        @(negedge DDRAM_CLK);
        chk("idle_stray_valid_dout", 64'(dout), 64'(0));
        chk("idle_stray_valid_ready", 64'(ready), 64'(1));

        do_write(21'h000005, 8'hA5, 0);
        do_write(21'h1FFFFF, 8'h5A, 2);
        do_read(21'h000013, 3, 2, 64'h0807060504030201, 4, 6);

        do_write(21'h000020, 8'h77, 0);
        chk("dout_held_after_write", 64'(dout), 64'(8'h04));

        // rd and we rising together: only the write runs, and the held rd starts nothing.
        @(negedge DDRAM_CLK);
        addr = 21'h000008;
        din  = 8'h3C;
        rd   = 1'b1;
        we   = 1'b1;
        we_cyc = 0;
        rd_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge DDRAM_CLK);
            if (bus.DDRAM_WE === 1'b1) we_cyc++;
            if (bus.DDRAM_RD === 1'b1) rd_cyc++;
        end
        we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge DDRAM_CLK);
            if (bus.DDRAM_RD === 1'b1) rd_cyc++;
        end
        chk("simul_we_cycles", 64'(we_cyc), 64'(1));
        chk("simul_rd_cycles", 64'(rd_cyc), 64'(0));
        chk("simul_ready", 64'(ready), 64'(1));
        do_read(21'h000008, 0, 1, 64'h1122334455667788, 1, 2);

        // Reset while waiting for read data aborts; late data is ignored.
        @(negedge DDRAM_CLK);
        addr = 21'h000013;
        rd   = 1'b1;
        @(negedge DDRAM_CLK);
        chk("abort_rd_issued", 64'(bus.DDRAM_RD), 64'(1));
        @(negedge DDRAM_CLK);
        chk("abort_in_wait_rd", 64'(bus.DDRAM_RD), 64'(0));
        chk("abort_in_wait_ready", 64'(ready), 64'(0));
        reset_n = 1'b0;
        rd      = 1'b0;
        #1;
        chk("abort_ready", 64'(ready), 64'(1));
        chk("abort_rd", 64'(bus.DDRAM_RD), 64'(0));
        chk("abort_dout", 64'(dout), 64'(0));
        @(negedge DDRAM_CLK);
        reset_n = 1'b1;
        bus.DDRAM_DOUT_READY = 1'b1;
        bus.DDRAM_DOUT       = 64'h0807060504030201;
        @(negedge DDRAM_CLK);
        bus.DDRAM_DOUT_READY = 1'b0;
        @(negedge DDRAM_CLK);
        chk("late_valid_dout", 64'(dout), 64'(0));
        chk("late_valid_ready", 64'(ready), 64'(1));

        // Repeat reads of one line; with the cache the second and third hit.
        do_read(21'h000013, 0, 1, 64'h0807060504030201, 1, 2);
        do_read(21'h000013, 1, 3, 64'h0807060504030201, CACHE ? 0 : 2, CACHE ? 1 : 5);
        do_write(21'h000013, 8'hEE, 0);
        do_read(21'h000013, 0, 2, 64'h08070605EE030201, CACHE ? 0 : 1, CACHE ? 1 : 3);

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
